// File: rtl/seq_det_event_recorder_if.sv
// Bus bundle for the detection event recorder: detector pulse and enables in,
// show-ahead record stream plus statistics out.
interface seq_det_event_recorder_if #(
    parameter int GAP_W = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    logic                     det;
    logic                     en;
    logic                     clr;
    logic                     rd_ready;
    logic                     rd_valid;
    logic [GAP_W+1:0]         rd_data;
    logic [$clog2(DEPTH):0]   level;
    logic [CNT_W-1:0]         total;
    logic                     ovf;

    modport master (
        output det, en, clr, rd_ready,
        input  rd_valid, rd_data, level, total, ovf
    );

    modport slave (
        input  det, en, clr, rd_ready,
        output rd_valid, rd_data, level, total, ovf
    );
endinterface

// File: rtl/seq_det_event_recorder.sv
// Records the cycle gap between successive enabled detections into a small
// show-ahead FIFO, with a running detection total and sticky overflow flag.
module seq_det_event_recorder #(
    parameter int GAP_W = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    seq_det_event_recorder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = GAP_W + 2;
    localparam logic [GAP_W-1:0] GAP_MAX  = {GAP_W{1'b1}};
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
    localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0]    LVL_ZERO = {LW{1'b0}};
    localparam logic [LW-1:0]    LVL_ONE  = LW'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [AW-1:0]    PTR_ZERO = {AW{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [EW-1:0]    ENT_ZERO = {EW{1'b0}};

    typedef enum logic [0:0] {
        WAIT_FIRST = 1'b0,
        TRACK      = 1'b1
    } state_t;

    state_t             r_state;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [EW-1:0]      r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [LW-1:0]      r_level;
    logic [CNT_W-1:0]   r_total;
    logic               r_ovf;

    logic               w_accept;
    logic               w_valid;
    logic               w_pop;
    logic               w_full;
    logic               w_push;
    logic [EW-1:0]      w_entry;

    // Record formatting: the first detection after reset/clear carries no gap.
    function automatic logic [EW-1:0] make_entry(input state_t st, input logic [GAP_W-1:0] gap);
        logic [EW-1:0] ent;
        case (st)
            WAIT_FIRST: ent = {1'b1, 1'b0, GAP_ZERO};
            TRACK:      ent = {1'b0, (gap == GAP_MAX), gap};
            default:    ent = ENT_ZERO;
        endcase
        return ent;
    endfunction

    // Push/pop decisions; a pop frees the slot a full FIFO needs this cycle.
    always_comb begin
        w_accept = 1'b0;
        w_valid  = 1'b0;
        w_pop    = 1'b0;
        w_full   = 1'b0;
        w_push   = 1'b0;
        w_entry  = ENT_ZERO;
        w_accept = bus.det & bus.en;
        w_valid  = (r_level != LVL_ZERO);
        w_pop    = w_valid & bus.rd_ready;
        w_full   = (r_level == LVL_FULL);
        if (w_accept) begin
            w_push  = ~w_full | w_pop;
            w_entry = make_entry(r_state, r_gap_cnt);
        end else begin
            w_push  = 1'b0;
            w_entry = ENT_ZERO;
        end
    end

    // Gap tracking FSM; advances only on enabled cycles, dropped detections included.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= WAIT_FIRST;
            r_gap_cnt <= GAP_ZERO;
        end else if (bus.clr) begin
            r_state   <= WAIT_FIRST;
            r_gap_cnt <= GAP_ZERO;
        end else if (bus.en) begin
            case (r_state)
                WAIT_FIRST: begin
                    if (bus.det) begin
                        r_state   <= TRACK;
                        r_gap_cnt <= GAP_ONE;
                    end else begin
                        r_state   <= WAIT_FIRST;
                        r_gap_cnt <= GAP_ZERO;
                    end
                end
                TRACK: begin
                    if (bus.det) begin
                        r_gap_cnt <= GAP_ONE;
                    end else if (r_gap_cnt != GAP_MAX) begin
                        r_gap_cnt <= r_gap_cnt + GAP_ONE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt;
                    end
                end
                default: begin
                    r_state   <= WAIT_FIRST;
                    r_gap_cnt <= GAP_ZERO;
                end
            endcase
        end else begin
            r_state   <= r_state;
            r_gap_cnt <= r_gap_cnt;
        end
    end

    // FIFO storage, pointers, occupancy and statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= ENT_ZERO;
            end
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
            r_level  <= LVL_ZERO;
            r_total  <= CNT_ZERO;
            r_ovf    <= 1'b0;
        end else if (bus.clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= ENT_ZERO;
            end
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
            r_level  <= LVL_ZERO;
            r_total  <= CNT_ZERO;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end else begin
                r_wr_ptr        <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
            if (w_accept) begin
                r_total <= r_total + CNT_ONE;
            end else begin
                r_total <= r_total;
            end
            if (w_accept & ~w_push) begin
                r_ovf <= 1'b1;
            end else begin
                r_ovf <= r_ovf;
            end
        end
    end

    assign bus.rd_valid = w_valid;
    assign bus.rd_data  = w_valid ? r_mem[r_rd_ptr] : ENT_ZERO;
    assign bus.level    = r_level;
    assign bus.total    = r_total;
    assign bus.ovf      = r_ovf;
endmodule

// File: tb/tb_seq_det_event_recorder.sv
// Self-checking bench for seq_det_event_recorder: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_seq_det_event_recorder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_det_event_recorder_if bus_if ();
    seq_det_event_recorder dut (.clk(clk), .rst(rst_n), .bus(bus_if));

    int total_checks = 0;
    int bad_checks   = 0;

    // Reference model: records are gap = enabled-cycle index difference, clipped.
    logic [9:0]  mq[$];
    logic [15:0] m_total;
    bit          m_ovf;
    bit          m_has_prev;
    int          m_idx;
    int          m_last;

    task automatic model_reset();
        mq.delete();
        m_total    = 16'd0;
        m_ovf      = 1'b0;
        m_has_prev = 1'b0;
        m_idx      = 0;
        m_last     = 0;
    endtask

    task automatic model_edge(input bit d, input bit e, input bit r, input bit c);
        bit         pop;
        int         gap;
        logic [9:0] ent;
        if (c) begin
            model_reset();
        end else begin
            pop = (mq.size() > 0) && r;
            if (e) m_idx++;
            if (d && e) begin
                gap = m_idx - m_last;
                if (!m_has_prev) ent = 10'h200;
                else if (gap >= 255) ent = {1'b0, 1'b1, 8'hFF};
                else ent = {1'b0, 1'b0, 8'(gap)};
                m_total++;
                m_has_prev = 1'b1;
                m_last     = m_idx;
                if (pop) void'(mq.pop_front());
                if (mq.size() < 4) mq.push_back(ent);
                else m_ovf = 1'b1;
            end else if (pop) begin
                void'(mq.pop_front());
            end
        end
    endtask

    function automatic logic [9:0] exp_head();
        return (mq.size() > 0) ? mq[0] : 10'd0;
    endfunction

    task automatic step(input bit d, input bit e, input bit r, input bit c);
        bus_if.det      = d;
        bus_if.en       = e;
        bus_if.rd_ready = r;
        bus_if.clr      = c;
        @(posedge clk);
        model_edge(d, e, r, c);
        #1;
    endtask

    task automatic test_reset();
        total_checks++;
        if (bus_if.rd_valid !== 1'b0) begin bad_checks++; $display("FAIL reset_valid: got %0d exp 0", bus_if.rd_valid); end
        total_checks++;
        if (bus_if.rd_data !== 10'd0) begin bad_checks++; $display("FAIL reset_data: got %0h exp 0", bus_if.rd_data); end
        total_checks++;
        if (bus_if.level !== 3'd0 || bus_if.total !== 16'd0 || bus_if.ovf !== 1'b0) begin
            bad_checks++; $display("FAIL reset_stats: level=%0d total=%0d ovf=%0d exp 0/0/0", bus_if.level, bus_if.total, bus_if.ovf);
        end
    endtask

    task automatic test_first_gap();
        for (int i = 1; i <= 8; i++) step(i == 5 || i == 8, 1'b1, 1'b0, 1'b0);
        total_checks++;
        if (bus_if.level !== 3'd2 || bus_if.total !== 16'd2 || bus_if.ovf !== 1'b0) begin
            bad_checks++; $display("FAIL first_stats: level=%0d total=%0d ovf=%0d exp 2/2/0", bus_if.level, bus_if.total, bus_if.ovf);
        end
        total_checks++;
        if (bus_if.rd_data !== 10'h200) begin bad_checks++; $display("FAIL first_entry: got %0h exp 200", bus_if.rd_data); end
        step(1'b0, 1'b1, 1'b1, 1'b0);
        total_checks++;
        if (bus_if.rd_data !== 10'h003 || bus_if.level !== 3'd1) begin
            bad_checks++; $display("FAIL first_gap: got %0h level %0d exp 003 level 1", bus_if.rd_data, bus_if.level);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_saturation();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (300) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        total_checks++;
        if (bus_if.rd_data !== 10'h1FF) begin bad_checks++; $display("FAIL sat_entry: got %0h exp 1ff", bus_if.rd_data); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        total_checks++;
        if (bus_if.rd_data !== 10'h002) begin bad_checks++; $display("FAIL sat_after: got %0h exp 002", bus_if.rd_data); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_overflow();
        logic [9:0] exp_list [4];
        exp_list = '{10'h200, 10'h001, 10'h001, 10'h001};
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0);
        total_checks++;
        if (bus_if.level !== 3'd4 || bus_if.total !== 16'd5 || bus_if.ovf !== 1'b1) begin
            bad_checks++; $display("FAIL ovf_stats: level=%0d total=%0d ovf=%0d exp 4/5/1", bus_if.level, bus_if.total, bus_if.ovf);
        end
        for (int i = 0; i < 4; i++) begin
            total_checks++;
            if (bus_if.rd_data !== exp_list[i] || bus_if.rd_data !== exp_head()) begin
                bad_checks++; $display("FAIL ovf_drain%0d: got %0h exp %0h", i, bus_if.rd_data, exp_list[i]);
            end
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
        total_checks++;
        if (bus_if.rd_valid !== 1'b0 || bus_if.rd_data !== 10'd0 || bus_if.ovf !== 1'b1) begin
            bad_checks++; $display("FAIL ovf_empty: valid=%0d data=%0h ovf=%0d exp 0/0/1", bus_if.rd_valid, bus_if.rd_data, bus_if.ovf);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_full_pop();
        logic [9:0] exp_list [4];
        exp_list = '{10'h001, 10'h001, 10'h001, 10'h002};
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        total_checks++;
        if (bus_if.level !== 3'd4 || bus_if.ovf !== 1'b0 || bus_if.total !== 16'd5) begin
            bad_checks++; $display("FAIL fullpop_stats: level=%0d ovf=%0d total=%0d exp 4/0/5", bus_if.level, bus_if.ovf, bus_if.total);
        end
        for (int i = 0; i < 4; i++) begin
            total_checks++;
            if (bus_if.rd_data !== exp_list[i]) begin
                bad_checks++; $display("FAIL fullpop_drain%0d: got %0h exp %0h", i, bus_if.rd_data, exp_list[i]);
            end
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_en_gating();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(i[0], 1'b0, 1'b0, 1'b0);
            total_checks++;
            if (bus_if.total !== 16'd1 || bus_if.level !== 3'd1) begin
                bad_checks++; $display("FAIL gate_hold%0d: total=%0d level=%0d exp 1/1", i, bus_if.total, bus_if.level);
            end
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        total_checks++;
        if (bus_if.rd_data !== 10'h004) begin bad_checks++; $display("FAIL gate_gap: got %0h exp 004", bus_if.rd_data); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
        total_checks++;
        if (bus_if.level !== 3'd3) begin bad_checks++; $display("FAIL arst_pre: level=%0d exp 3", bus_if.level); end
        bus_if.det = 1'b0;
        bus_if.en  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total_checks++;
        if (bus_if.rd_valid !== 1'b0 || bus_if.level !== 3'd0 || bus_if.total !== 16'd0 || bus_if.ovf !== 1'b0) begin
            bad_checks++; $display("FAIL arst_now: valid=%0d level=%0d total=%0d ovf=%0d exp 0", bus_if.rd_valid, bus_if.level, bus_if.total, bus_if.ovf);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        total_checks++;
        if (bus_if.rd_data !== 10'h200) begin bad_checks++; $display("FAIL arst_first: got %0h exp 200", bus_if.rd_data); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_clr_midstream();
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        total_checks++;
        if (bus_if.rd_valid !== 1'b0 || bus_if.rd_data !== 10'd0 || bus_if.level !== 3'd0 || bus_if.total !== 16'd0 || bus_if.ovf !== 1'b0) begin
            bad_checks++; $display("FAIL clr_now: valid=%0d level=%0d total=%0d exp 0", bus_if.rd_valid, bus_if.level, bus_if.total);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        total_checks++;
        if (bus_if.rd_data !== 10'h200 || bus_if.total !== 16'd1) begin
            bad_checks++; $display("FAIL clr_first: got %0h total %0d exp 200 total 1", bus_if.rd_data, bus_if.total);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        bit d, e, r, c;
        int rd_pct;
        for (int i = 0; i < 800; i++) begin
            rd_pct = ((i / 100) % 2 == 1) ? 80 : 20;
            d = ($urandom_range(0, 2) == 0);
            e = ($urandom_range(0, 9) != 0);
            r = ($urandom_range(0, 99) < rd_pct);
            c = ($urandom_range(0, 199) == 0);
            step(d, e, r, c);
            total_checks++;
            if (bus_if.rd_valid !== (mq.size() > 0) || bus_if.rd_data !== exp_head() ||
                bus_if.level !== 3'(mq.size()) || bus_if.total !== m_total || bus_if.ovf !== m_ovf) begin
                bad_checks++;
                $display("FAIL rand%0d: valid=%0d data=%0h level=%0d total=%0d ovf=%0d exp %0d/%0h/%0d/%0d/%0d",
                         i, bus_if.rd_valid, bus_if.rd_data, bus_if.level, bus_if.total, bus_if.ovf,
                         (mq.size() > 0), exp_head(), mq.size(), m_total, m_ovf);
            end
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus_if.det      = 1'b0;
        bus_if.en       = 1'b0;
        bus_if.clr      = 1'b0;
        bus_if.rd_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_first_gap();
        test_saturation();
        test_overflow();
        test_full_pop();
        test_en_gating();
        test_async_reset();
        test_clr_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end
endmodule

// File: doc/seq_det_event_recorder.md
# seq_det_event_recorder

Downstream stage of the serial sequence detector. It consumes the detector's one-bit `out` pulse stream and, for each accepted detection, measures the cycle gap since the previous detection. Each record is queued in a small show-ahead FIFO and drained by a valid/ready reader, the debug/statistics port. It also keeps a running detection total and a sticky overflow flag.

## Interface
- `GAP_W`, 8: width of the gap field; gap saturates at 2^GAP_W-1.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of the running detection total.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset. Low clears all state immediately; it is released synchronously by the integration.
- `det` input 1: detection pulse, driven from the detector's `out` register.
- `en` input 1: count/accept enable.
- `clr` input 1: synchronous clear of all state, same effect as reset but at the next edge.
- `rd_ready` input 1: reader accepts the head entry.
- `rd_valid` output 1: FIFO non-empty.
- `rd_data` output GAP_W+2: head entry {first, sat, gap[GAP_W-1:0]}; all zeros when empty.
- `level` output $clog2(DEPTH)+1: entries currently held.
- `total` output CNT_W: detections seen with `en`=1, both pushed and dropped; wraps modulo 2^CNT_W.
- `ovf` output 1: sticky; set when a detection is dropped because the FIFO is full.

## Operation
- **Reset values.** rd_valid=0, rd_data=0, level=0, total=0, ovf=0, FSM=WAIT_FIRST, gap_cnt=0.
- **Priority.** rst (async) > clr > normal operation.
- **FSM: WAIT_FIRST.**
  - gap_cnt held at 0.
  - det&en → push {1,0,0}, gap_cnt←1, go to TRACK.
- **FSM: TRACK.**
  - en&!det → gap_cnt←min(gap_cnt+1, 2^GAP_W-1).
  - en&det → push {0, sat, gap_cnt}, gap_cnt←1.
  - sat=1 iff gap_cnt equals 2^GAP_W-1 at the time of capture.
- **en=0.** det is ignored, gap_cnt holds, total holds. FIFO reads continue.
- **Gap meaning.** Detections on enabled cycles t and t+N (N < 2^GAP_W-1) record gap=N.
- **Push rule.** Push occurs iff det&en and (level<DEPTH or pop this cycle).
- **Full FIFO.** If full and no pop, the entry is dropped and ovf←1. total still increments. FSM and gap_cnt update exactly as for an accepted detection.
- **Pop rule.** Pop occurs when rd_valid&rd_ready.
- **Simultaneous push and pop.** Level is unchanged. The new entry is written at the tail and the head advances.
- **Simultaneous push and pop on empty FIFO.** Not possible: rd_valid=0 blocks the pop, so the push alone occurs.
- **Pointers.** Read/write pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from `level`.
- **ovf.** Cleared only by rst or clr.

## Timing
- det&en at edge t → entry visible on rd_data with rd_valid=1 after edge t, i.e. in cycle t+1. Latency is 1 cycle.
- Pop at edge t → next entry (or zeros) on rd_data in cycle t+1. rd_data and rd_valid are driven combinationally from registered FIFO state only; there is no combinational path from rd_ready.
- level, total and ovf update at the same edge as the causing push, pop or drop.
- clr asserted at edge t → all outputs read their reset values in cycle t+1. det in the same cycle is ignored.
- rst low → outputs read their reset values without waiting for a clock edge, including mid-stream with a full FIFO.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- **First detection and gap.** Reset, en=1, rd_ready=0; det on enabled cycles 5 and 8 → entries {1,0,0} then {0,0,3}; level=2, total=2, ovf=0.
- **Gap saturation (GAP_W=8).**
  - After a first detection, hold det=0 for 300 cycles, then det → entry {0,1,255}.
  - Next det 2 cycles later → {0,0,2}.
- **Overflow (DEPTH=4).** rd_ready=0; five detections → level=4, total=5, ovf=1. Then drain 4 entries → the fifth is absent, ovf stays 1.
- **Full plus simultaneous pop and det.** With the FIFO full, rd_ready=1 and det=1 in the same cycle → level stays 4, ovf stays 0, new entry appears at the tail.
- **en gating.** en=0 for 10 cycles with det toggling → total, level and gap_cnt unchanged. The next enabled det records the gap counted over enabled cycles only.
- **Reset and clear mid-stream.**
  - Drop rst asynchronously between edges with level=3 → rd_valid, level, total and ovf read 0 before the next edge.
  - Repeat using clr → identical result one edge later.
  - The following det records first=1.
